// File: rtl/prog_instr_mem.sv
// Instruction memory that is zero-filled after reset, loaded byte-serially by a host, and fetched by byte address.
// Latency: a fetch is combinational (REG_OUT=0) or takes one cycle (REG_OUT=1). A loaded word is written on the edge of the byte that completes it.
// Backpressure: PRG_READY stays high for the whole LOAD session. Bytes beyond capacity are swallowed and flagged in PRG_ERR.
module prog_instr_mem #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 128,
    parameter int REG_OUT = 0
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [ADDR_W-1:0]            ADDR,
    output logic [DATA_W-1:0]            Q,
    output logic                         MISALIGN,
    output logic                         BUSY,
    input  logic                         PRG_START,
    input  logic                         PRG_VALID,
    input  logic [7:0]                   PRG_DATA,
    input  logic                         PRG_LAST,
    output logic                         PRG_READY,
    output logic                         PRG_ERR,
    output logic [$clog2(DEPTH+1)-1:0]   WORDS_LOADED
);

    localparam int BPW = DATA_W / 8;                           // bytes per word
    localparam int SH  = $clog2(BPW);                          // byte-offset bits in ADDR
    localparam int CW  = $clog2(DEPTH + 1);                    // pointer can reach DEPTH
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;      // word index width
    localparam int BCW = $clog2(BPW);                          // byte-in-word counter width
    localparam int AW  = DATA_W - 8;                           // assembly holds all but the final byte

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     fill_q,  fill_d;
    logic [CW-1:0]     ptr_q,   ptr_d;
    logic [BCW-1:0]    bcnt_q,  bcnt_d;
    logic [AW-1:0]     asm_q,   asm_d;
    logic              err_q,   err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [IW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // The incoming byte lands in the LSB. On an early PRG_LAST, the word is shifted up so the missing low bytes become zero.
    logic [DATA_W-1:0] word_next;
    logic [DATA_W-1:0] word_pad;
    assign word_next = {asm_q, PRG_DATA};
    assign word_pad  = word_next << (8 * (BPW - 1 - int'(bcnt_q)));

    // Control state registers, cleared asynchronously so a reset mid-load restarts the zero fill.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_INIT;
            fill_q  <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: the zero-fill sequencer, session start/restart, byte packing and overflow detection.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        ptr_d     = ptr_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = fill_q;
        mem_wdata = '0;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = fill_q;
                mem_wdata = '0;
                fill_d    = fill_q + IW'(1);
                if (fill_q == IW'(DEPTH - 1)) begin
                    fill_d  = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (PRG_START) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    bcnt_d  = '0;
                    asm_d   = '0;
                    err_d   = 1'b0;
                end
            end

            ST_LOAD: begin
                if (PRG_START) begin
                    // Restart: any partial word is dropped. Words already written stay in memory.
                    ptr_d  = '0;
                    bcnt_d = '0;
                    asm_d  = '0;
                    err_d  = 1'b0;
                end else if (PRG_VALID) begin
                    if (ptr_q == CW'(DEPTH)) begin
                        // The memory is full. Accept the byte so the host never stalls, but only flag it.
                        err_d = 1'b1;
                    end else if ((bcnt_q == BCW'(BPW - 1)) || PRG_LAST) begin
                        mem_we    = 1'b1;
                        mem_waddr = ptr_q[IW-1:0];
                        mem_wdata = word_pad;
                        ptr_d     = ptr_q + CW'(1);
                        bcnt_d    = '0;
                        asm_d     = '0;
                    end else begin
                        bcnt_d = bcnt_q + BCW'(1);
                        asm_d  = word_next[AW-1:0];
                    end
                    if (PRG_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    // Memory array. The zero-fill sequencer and the loader share this single write port.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // The write pointer saturates at DEPTH, so it equals the number of words written this session.
    assign WORDS_LOADED = ptr_q;
    assign PRG_ERR      = err_q;
    assign BUSY         = (state_q != ST_IDLE);
    assign PRG_READY    = (state_q == ST_LOAD);

    // Fetch path. Reads are blanked while busy, so a fetch never observes a half-loaded image.
    logic [ADDR_W-1:0] fidx;
    logic              fin_range;
    logic [DATA_W-1:0] q_d;
    logic              mis_d;

    assign fidx      = ADDR >> SH;
    assign fin_range = ({1'b0, fidx} < (ADDR_W + 1)'(DEPTH));
    assign q_d       = (fin_range && !BUSY) ? mem[fidx[IW-1:0]] : '0;
    assign mis_d     = (ADDR[SH-1:0] != '0);

    if (REG_OUT != 0) begin : g_reg_out
        logic [DATA_W-1:0] q_q;
        logic              mis_q;

        // Registered fetch: Q and MISALIGN follow ADDR by one cycle.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                q_q   <= '0;
                mis_q <= 1'b0;
            end else begin
                q_q   <= q_d;
                mis_q <= mis_d;
            end
        end

        assign Q        = q_q;
        assign MISALIGN = mis_q;
    end else begin : g_comb_out
        assign Q        = q_d;
        assign MISALIGN = mis_d;
    end

endmodule

// File: tb/tb_prog_instr_mem.sv
// Bench for prog_instr_mem: three instances (default, 4-word, registered 9-bit address) share one loader stream.
// Latency: the reference image is updated per session and compared on full address sweeps.
// Backpressure: PRG_READY is expected high throughout each session, including overflow bytes.
module tb_prog_instr_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [8:0] addr;
    logic       prg_start, prg_valid, prg_last;
    logic [7:0] prg_data;

    logic [15:0] q_a, q_b, q_c;
    logic        mis_a, mis_b, mis_c;
    logic        busy_a, busy_b, busy_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic        err_a, err_b, err_c;
    logic [7:0]  wl_a, wl_c;
    logic [2:0]  wl_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference image: a 128-word memory and a 4-word memory.
    logic [15:0] ref_big [128];
    logic [15:0] ref_sml [4];
    logic [7:0]  q_sess [$];
    bit          in_sess = 1'b0;
    int          exp_wl_big = 0;
    int          exp_wl_sml = 0;
    bit          exp_err_sml = 1'b0;

    prog_instr_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .REG_OUT(0)) u_a (
        .CLK(clk), .RESET(rst), .ADDR(addr[7:0]), .Q(q_a), .MISALIGN(mis_a), .BUSY(busy_a),
        .PRG_START(prg_start), .PRG_VALID(prg_valid), .PRG_DATA(prg_data), .PRG_LAST(prg_last),
        .PRG_READY(rdy_a), .PRG_ERR(err_a), .WORDS_LOADED(wl_a));

    prog_instr_mem #(.DATA_W(16), .ADDR_W(9), .DEPTH(4), .REG_OUT(0)) u_b (
        .CLK(clk), .RESET(rst), .ADDR(addr), .Q(q_b), .MISALIGN(mis_b), .BUSY(busy_b),
        .PRG_START(prg_start), .PRG_VALID(prg_valid), .PRG_DATA(prg_data), .PRG_LAST(prg_last),
        .PRG_READY(rdy_b), .PRG_ERR(err_b), .WORDS_LOADED(wl_b));

    prog_instr_mem #(.DATA_W(16), .ADDR_W(9), .DEPTH(128), .REG_OUT(1)) u_c (
        .CLK(clk), .RESET(rst), .ADDR(addr), .Q(q_c), .MISALIGN(mis_c), .BUSY(busy_c),
        .PRG_START(prg_start), .PRG_VALID(prg_valid), .PRG_DATA(prg_data), .PRG_LAST(prg_last),
        .PRG_READY(rdy_c), .PRG_ERR(err_c), .WORDS_LOADED(wl_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply a session to the reference image: bytes pair up MSB-first into words. With LAST the tail is
    // zero-padded; on a restart only complete words survive. Each memory keeps only what fits.
    task automatic commit(input bit with_last);
        int n;
        int nw;
        logic [15:0] v;
        n  = q_sess.size();
        nw = with_last ? (n + 1) / 2 : n / 2;
        for (int w = 0; w < nw; w++) begin
            v[15:8] = q_sess[2*w];
            v[7:0]  = (2*w + 1 < n) ? q_sess[2*w + 1] : 8'h00;
            if (w < 128) ref_big[w] = v;
            if (w < 4)   ref_sml[w] = v;
        end
        exp_wl_big  = (nw < 128) ? nw : 128;
        exp_wl_sml  = (nw < 4) ? nw : 4;
        exp_err_sml = (n > 8);
        q_sess.delete();
    endtask

    task automatic rd(input logic [8:0] a);
        int idx;
        logic [31:0] eb;
        logic [31:0] ec;
        idx = int'(a) >> 1;
        eb = 32'd0;
        ec = 32'd0;
        if (idx < 4)   eb = 32'(ref_sml[idx]);
        if (idx < 128) ec = 32'(ref_big[idx]);
        @(negedge clk);
        addr = a;
        #1;
        chk("q_a", 32'(q_a), 32'(ref_big[a[7:1]]));
        chk("mis_a", 32'(mis_a), 32'(a[0]));
        chk("q_b", 32'(q_b), eb);
        chk("mis_b", 32'(mis_b), 32'(a[0]));
        @(posedge clk);
        #1;
        chk("q_c", 32'(q_c), ec);
        chk("mis_c", 32'(mis_c), 32'(a[0]));
    endtask

    task automatic sweep();
        for (int i = 0; i < 256; i += 2) rd(9'(i));
        rd(9'd3);
        rd(9'd7);
        rd(9'd8);
        rd(9'h100);
        rd(9'h1FF);
    endtask

    task automatic start_sess();
        if (in_sess) commit(1'b0);
        @(negedge clk);
        prg_valid = 1'b0;
        prg_last  = 1'b0;
        prg_start = 1'b1;
        @(negedge clk);
        prg_start = 1'b0;
        in_sess   = 1'b1;
        #1;
        chk("start_rdy", 32'(rdy_a), 32'd1);
        chk("start_busy", 32'(busy_a), 32'd1);
        chk("start_err", 32'(err_b), 32'd0);
        chk("start_wl", 32'(wl_a), 32'd0);
    endtask

    // Gap cycles toggle LAST without VALID; those must have no effect.
    task automatic send_byte(input logic [7:0] b, input bit lst, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            prg_valid = 1'b0;
            prg_last  = 1'($urandom_range(0, 1));
            prg_data  = 8'($urandom);
        end
        @(negedge clk);
        prg_valid = 1'b1;
        prg_data  = b;
        prg_last  = lst;
        q_sess.push_back(b);
        if (lst) begin
            commit(1'b1);
            in_sess = 1'b0;
        end
    endtask

    task automatic end_chk();
        @(negedge clk);
        prg_valid = 1'b0;
        prg_last  = 1'b0;
        #1;
        chk("end_busy", 32'(busy_a), 32'd0);
        chk("end_rdy", 32'(rdy_a), 32'd0);
        chk("end_wl_a", 32'(wl_a), 32'(exp_wl_big));
        chk("end_wl_c", 32'(wl_c), 32'(exp_wl_big));
        chk("end_wl_b", 32'(wl_b), 32'(exp_wl_sml));
        chk("end_err_b", 32'(err_b), 32'(exp_err_sml));
        chk("end_err_a", 32'(err_a), 32'd0);
    endtask

    // Release reset and count busy cycles. A START pulse during the fill must be ignored.
    task automatic init_phase();
        int ca;
        int cb;
        ca = 0;
        cb = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            prg_start = (i == 2);
            #1;
            if (busy_a) ca++;
            if (busy_b) cb++;
            @(negedge clk);
        end
        prg_start = 1'b0;
        chk("init_len_a", 32'(ca), 32'd128);
        chk("init_len_b", 32'(cb), 32'd4);
        chk("init_busy_c", 32'(busy_c), 32'd0);
        chk("init_rdy_a", 32'(rdy_a), 32'd0);
    endtask

    initial begin
        #1000000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len;
        rst       = 1'b0;
        addr      = 9'd3;
        prg_start = 1'b0;
        prg_valid = 1'b0;
        prg_last  = 1'b0;
        prg_data  = 8'h00;
        foreach (ref_big[i]) ref_big[i] = 16'h0000;
        foreach (ref_sml[i]) ref_sml[i] = 16'h0000;
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 32'd1);
        chk("rst_rdy", 32'(rdy_a), 32'd0);
        chk("rst_err", 32'(err_b), 32'd0);
        chk("rst_wl", 32'(wl_a), 32'd0);
        chk("rst_q_a", 32'(q_a), 32'd0);
        chk("rst_q_c", 32'(q_c), 32'd0);
        chk("rst_mis_c", 32'(mis_c), 32'd0);

        init_phase();
        sweep();

        // Two full words.
        start_sess();
        send_byte(8'hF0, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h01, 1'b1, 0);
        end_chk();
        chk("tp1_wl", 32'(wl_a), 32'd2);
        rd(9'd0);
        @(negedge clk);
        addr = 9'd2;
        #1;
        chk("tp1_q2", 32'(q_a), 32'h0001);
        chk("lat_hold", 32'(q_c), 32'hF001);
        @(posedge clk);
        #1;
        chk("lat_upd", 32'(q_c), 32'h0001);
        sweep();

        // Partial final word; fetch is blanked while loading.
        start_sess();
        addr = 9'd0;
        #1;
        chk("busy_q_zero", 32'(q_a), 32'd0);
        send_byte(8'h12, 1'b0, 0);
        send_byte(8'h34, 1'b0, 0);
        send_byte(8'h56, 1'b1, 0);
        end_chk();
        rd(9'd2);
        chk("tp2_q2", 32'(q_a), 32'h5600);
        sweep();

        // The same stream with VALID gaps.
        start_sess();
        send_byte(8'h12, 1'b0, 2);
        send_byte(8'h34, 1'b0, 1);
        send_byte(8'h56, 1'b1, 3);
        end_chk();
        sweep();

        // Overflow on the 4-word instance: ERR rises on byte 9, and READY holds.
        start_sess();
        for (int i = 0; i < 10; i++) begin
            send_byte(8'($urandom), (i == 9), 0);
            @(negedge clk);
            prg_valid = 1'b0;
            prg_last  = 1'b0;
            #1;
            chk("ovf_err", 32'(err_b), 32'(i >= 8));
            chk("ovf_rdy", 32'(rdy_b), 32'(i < 9));
            chk("ovf_wl", 32'(wl_b), 32'(((i + 1) / 2 < 4) ? (i + 1) / 2 : 4));
        end
        end_chk();
        sweep();

        // Randomised sessions (lengths past 8 overflow the small instance).
        for (int s = 0; s < 6; s++) begin
            start_sess();
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                send_byte(8'($urandom), (j == len - 1), $urandom_range(0, 2));
            end
            end_chk();
            sweep();
        end

        // Restart mid-session: complete words stay, the partial byte is dropped.
        start_sess();
        for (int j = 0; j < 5; j++) send_byte(8'($urandom), 1'b0, 0);
        start_sess();
        send_byte(8'($urandom), 1'b0, 0);
        send_byte(8'($urandom), 1'b1, 0);
        end_chk();
        sweep();
        for (int k = 0; k < 40; k++) rd(9'($urandom));

        // Reset during a load aborts the session and re-zeroes everything.
        start_sess();
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h5A, 1'b0, 1);
        send_byte(8'hC3, 1'b0, 0);
        @(negedge clk);
        prg_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("abort_rdy_a", 32'(rdy_a), 32'd0);
        chk("abort_rdy_b", 32'(rdy_b), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd1);
        chk("abort_wl", 32'(wl_a), 32'd0);
        foreach (ref_big[i]) ref_big[i] = 16'h0000;
        foreach (ref_sml[i]) ref_sml[i] = 16'h0000;
        q_sess.delete();
        in_sess = 1'b0;
        init_phase();
        sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
